// File: rtl/seg_pkg.sv
// Shared seven-segment constants: active-low abcdefg patterns (seg[6]=a .. seg[0]=g).
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n holds the glyph for hex nibble n; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: per-digit slots with an anode-off guard,
// frame-wide input shadowing, leading-zero and per-digit blanking.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 2,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lz_blank,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW != 0 ? '1 : '0;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] sh_digits;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_blank;
  logic                  sh_lz;

  logic                  wrap_slot;
  logic                  wrap_frame;
  logic                  slot_on;
  logic                  lit;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic [N_DIGITS-1:0]   onehot;
  logic [N_DIGITS-1:0]   lz_dark;
  logic                  zero_run;

  assign wrap_slot  = cnt == CW'(REFRESH_DIV - 1);
  assign wrap_frame = wrap_slot && (idx == IW'(N_DIGITS - 1));
  assign slot_on    = en && (cnt >= CW'(GUARD));
  assign nib        = sh_digits[4*idx +: 4];

  seg_decode u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // Walk down from the most-significant digit; a digit is dark while every
  // nibble at or above it is zero. Digit 0 is never considered.
  always_comb begin
    lz_dark  = '0;
    zero_run = sh_lz;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (sh_digits[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_run;
    end
  end

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  assign lit = slot_on && !sh_blank[idx] && !lz_dark[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      sh_lz      <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= slot_on ? (AN_ACTIVE_LOW != 0 ? ~onehot : onehot) : AN_OFF;
      seg        <= lit ? dec_seg : SEG_BLANK;
      dp         <= !(lit && sh_dp[idx]);
      frame_tick <= en && wrap_frame;
      if (en) begin
        if (wrap_slot) begin
          cnt <= '0;
          idx <= wrap_frame ? '0 : idx + IW'(1);
        end else begin
          cnt <= cnt + CW'(1);
        end
        // Shadows swap on the wrap edge so a whole frame sees one snapshot.
        if (wrap_frame) begin
          sh_digits <= digits;
          sh_dp     <= dp_in;
          sh_blank  <= blank_mask;
          sh_lz     <= lz_blank;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboarded bench: a time-based reference model queues expected outputs each
// clock; a negedge monitor pops and compares.
module tb_seven_seg_scan;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int G   = 2;
  localparam int FR  = N * DIV;
  localparam int DIV1 = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        lz = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  bmask = '0;

  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        ft;
  logic [0:0]  an1;
  logic [6:0]  seg1;
  logic        dp1;
  logic        ft1;

  always #5 clk = ~clk;

  seven_seg_scan #(.N_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(G), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .blank_mask(bmask), .lz_blank(lz), .an(an), .seg(seg), .dp(dp), .frame_tick(ft)
  );

  seven_seg_scan #(.N_DIGITS(1), .REFRESH_DIV(DIV1), .GUARD(2), .AN_ACTIVE_LOW(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .digits(4'h8), .dp_in(1'b0),
    .blank_mask(1'b0), .lz_blank(1'b0), .an(an1), .seg(seg1), .dp(dp1), .frame_tick(ft1)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       cs;
    logic       an1;
    logic [6:0] seg1;
    logic       cs1;
    logic       ft1;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: k counts enabled clocks since reset, so slot and digit
  // follow from plain division; shadows are the inputs seen at each frame boundary.
  int          k = 0;
  int          k1 = 0;
  logic [15:0] s_dig = '0;
  logic [3:0]  s_dp = '0;
  logic [3:0]  s_bm = '0;
  logic        s_lz = 1'b0;

  function automatic logic is_dark(input int d);
    logic z = 1'b1;
    for (int j = d; j < N; j++) if (s_dig[4*j +: 4] != 4'h0) z = 1'b0;
    return s_bm[d] || (s_lz && d > 0 && z);
  endfunction

  function automatic exp_t dark_e();
    exp_t e;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0; e.cs = 1'b1;
    e.an1 = 1'b0; e.seg1 = 7'h7F; e.cs1 = 1'b1; e.ft1 = 1'b0;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    int   c, d, c1;
    logic lit;
    if (!rst_n) begin
      k = 0; k1 = 0; s_dig = '0; s_dp = '0; s_bm = '0; s_lz = 1'b0;
      q.delete();
      q.push_back(dark_e());
    end else begin
      e = dark_e();
      if (en) begin
        c = k % DIV;
        d = (k / DIV) % N;
        lit = (c >= G) && !is_dark(d);
        e.an  = (c >= G) ? ~(4'b0001 << d) : 4'hF;
        e.cs  = (c >= G);
        e.seg = lit ? hex7(s_dig[4*d +: 4]) : 7'h7F;
        e.dp  = !(lit && s_dp[d]);
        k++;
        e.ft  = (k % FR == 0);
        if (k % FR == 0) begin
          s_dig = digits; s_dp = dp_in; s_bm = bmask; s_lz = lz;
        end
      end
      c1 = k1 % DIV1;
      e.an1  = (c1 >= 2);
      e.cs1  = (c1 >= 2);
      e.seg1 = (k1 / DIV1 == 0) ? hex7(4'h0) : hex7(4'h8);
      k1++;
      e.ft1  = (k1 % DIV1 == 0);
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", 32'(an), 32'(e.an));
      chk("frame_tick", 32'(ft), 32'(e.ft));
      if (e.cs) begin
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
      end
      chk("an1", 32'(an1), 32'(e.an1));
      chk("frame_tick1", 32'(ft1), 32'(e.ft1));
      chk("dp1", 32'(dp1), 32'(1'b1));
      if (e.cs1) chk("seg1", 32'(seg1), 32'(e.seg1));
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after the edge that raised frame_tick, i.e. at
  // the start of a frame (slot 0, count 0).
  task automatic wait_ft();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ft && n < 4 * FR);
    chk("frame_tick_seen", 32'(ft), 32'(1'b1));
  endtask

  task automatic chk_dark_now(input string tag);
    chk({tag, "_an"}, 32'(an), 32'(4'hF));
    chk({tag, "_seg"}, 32'(seg), 32'(7'h7F));
    chk({tag, "_dp"}, 32'(dp), 32'(1'b1));
    chk({tag, "_ft"}, 32'(ft), 32'(1'b0));
  endtask

  initial begin
    run(3);
    chk_dark_now("reset");
    rst_n = 1'b1;
    en = 1'b1;

    // Plain scan; the first frame still shows shadow zeros.
    digits = 16'h12AF;
    run(2 * FR);

    // Leading-zero blanking.
    lz = 1'b1; digits = 16'h0050;
    run(2 * FR);
    digits = 16'h0000;
    run(2 * FR);
    lz = 1'b0;

    // Mid-frame change during digit 1's slot stays invisible until the next frame.
    digits = 16'h1111;
    wait_ft();
    run(DIV + 4);
    digits = 16'h2222;
    wait_ft();
    run(FR);

    // Pause with digit 2 at count 5.
    wait_ft();
    run(2 * DIV + 5);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(FR);

    // Reset in the middle of a slot, then per-digit blanking incl. dp.
    run(11);
    rst_n = 1'b0;
    #1;
    chk_dark_now("async_reset");
    run(2);
    rst_n = 1'b1;
    digits = 16'h3C7E; bmask = 4'b0100; dp_in = 4'b0100;
    run(3 * FR);

    // Randomised traffic.
    for (int r = 0; r < 150; r++) begin
      run($urandom_range(1, 20));
      digits = 16'($urandom >> (4 * $urandom_range(0, 4)));
      dp_in  = 4'($urandom);
      bmask  = 4'($urandom & $urandom);
      lz     = 1'($urandom);
      en     = ($urandom_range(0, 7) != 0);
    end
    en = 1'b1;
    run(2 * FR);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clocks per digit slot (legal >= GUARD+2).
REQ-003 SHALL have parameter GUARD, default 2, clocks per slot with all anodes off (anti-ghosting).
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1, anode polarity (1 = active-low anodes).
REQ-005 SHALL use one clock and asynchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1: scan enable.
REQ-007 SHALL have port digits, input, 4*N_DIGITS: hex nibbles; nibble i drives digit i; digit 0 is least significant.
REQ-008 SHALL have port dp_in, input, N_DIGITS: decimal point request per digit, 1 = lit.
REQ-009 SHALL have port blank_mask, input, N_DIGITS: 1 = force digit dark.
REQ-010 SHALL have port lz_blank, input, 1: leading-zero blanking enable.
REQ-011 SHALL have port an, output, N_DIGITS: one-hot digit select, polarity per AN_ACTIVE_LOW.
REQ-012 SHALL have port seg, output, 7: active-low segments, seg[6]=a through seg[0]=g.
REQ-013 SHALL have port dp, output, 1: active-low decimal point.
REQ-014 SHALL have port frame_tick, output, 1: one-cycle pulse when the digit index wraps to 0.

Function
REQ-015 SHALL run a prescaler cnt counting 0..REFRESH_DIV-1 while en=1; at the terminal count cnt returns to 0 and digit index idx advances by one.
REQ-016 SHALL wrap idx from N_DIGITS-1 to 0 and assert frame_tick for exactly that cycle.
REQ-017 SHALL copy digits, dp_in, blank_mask and lz_blank into shadow registers on the same clock that idx wraps to 0; the displayed frame uses only shadow values, so mid-frame input changes do not appear until the next frame.
REQ-018 SHALL drive all anodes inactive while cnt < GUARD, and drive only anode idx active for the rest of the slot.
REQ-019 SHALL register an, seg and dp; outputs reflect the cnt/idx value of the previous clock (1-cycle latency).
REQ-020 SHALL decode nibbles active-low abcdefg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-021 SHALL treat a digit as dark (seg=1111111, dp=1) when its shadow blank_mask bit is 1.
REQ-022 SHALL treat a digit as dark when it is leading-zero blanked: shadow lz_blank=1, shadow nibble is 0, and all more-significant nibbles are 0. Digit 0 is never leading-zero blanked.
REQ-023 SHALL drive dp low only for a non-dark digit whose shadow dp_in bit is 1.
REQ-024 SHALL respond to en=0 as follows: cnt and idx hold, shadows hold, all anodes go inactive, seg=1111111, dp=1 on the next clock, and frame_tick=0. On return to en=1, scanning resumes from the held cnt/idx.
REQ-025 SHALL, for N_DIGITS=1, still pulse frame_tick every REFRESH_DIV clocks, and idx stays 0.

Reset
REQ-026 SHALL respond to rst_n=0, immediately and asynchronously, with: cnt=0, idx=0, shadows=0, an all inactive, seg=1111111, dp=1, frame_tick=0.
REQ-027 SHALL treat the first frame after reset as showing shadow zeros until the first wrap; if a reset occurs mid-slot, the slot is abandoned with no partial output.

Structure
REQ-028 SHALL place the segment encoding constants (REQ-020) and the blank pattern 1111111 in a shared package seg_pkg.
REQ-029 SHALL put the nibble-to-segment decode in sub-module seg_decode (combinational, 4-bit in, 7-bit out); seven_seg_scan instantiates one.
REQ-030 SHALL size cnt and idx with clog2 widths derived from the parameters, with at least 1 bit each.

Verification
REQ-031 SHALL cover this scan check: N_DIGITS=4, REFRESH_DIV=8, GUARD=2, digits=16'h12AF. Required: the an sequence cycles through digits 0..3, each active for 6 of 8 clocks; seg shows F,A,2,1 patterns; frame_tick fires every 32 clocks.
REQ-032 SHALL cover leading-zero blanking: lz_blank=1, digits=16'h0050. Required: digits 3 and 2 dark, digits 1 and 0 show 5 and 0. With digits=16'h0000, only digit 0 shows 0.
REQ-033 SHALL cover shadowing: change digits from 16'h1111 to 16'h2222 during digit 1's slot. Required: digits 2 and 3 still show 1 in that frame, and all digits show 2 from the next frame_tick.
REQ-034 SHALL cover the enable pause: drop en during digit 2 at cnt=5 for 20 clocks. Required: dark outputs from the next clock, no frame_tick, and digit 2 resumes at cnt=5.
REQ-035 SHALL cover reset and blanking: assert rst_n low mid-slot. Required: outputs go dark asynchronously and idx=0 after release. Then blank_mask=4'b0100 with dp_in=4'b0100: digit 2 is fully dark, including dp.
